// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and requester IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_e;

    // Round-robin choice: a lone requester wins, a tie goes to the port not granted last.
    function automatic gnt_e rr_pick(input logic f_req, input logic d_req, input gnt_e last);
        gnt_e win;
        if (f_req && d_req) begin
            win = (last == GNT_DATA) ? GNT_FETCH : GNT_DATA;
        end else if (d_req) begin
            win = GNT_DATA;
        end else begin
            win = GNT_FETCH;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker; remembers the last granted port across grants.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic f_req_i,
    input  logic d_req_i,
    input  logic upd_i,
    output gnt_e win_o
);

    gnt_e last_q;
    gnt_e last_d;

    // Winner selection and next value of the last-grant register.
    always_comb begin
        win_o  = rr_pick(f_req_i, d_req_i, last_q);
        last_d = last_q;
        if (upd_i) begin
            last_d = win_o;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant register; resets to data so fetch wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_DATA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port tri-state memory between fetch and load/store ports;
// every memory pin is a register, so no request input reaches mem_* combinationally.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [AWIDTH-1:0] f_addr,
    output logic              f_done,
    output logic [DWIDTH-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_done,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data,
    output logic              busy
);

    state_e            state_q;
    gnt_e              gnt_q;
    gnt_e              win_s;
    logic              upd_s;
    logic [DWIDTH-1:0] wdata_q;
    logic              drive_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic              f_done_q;
    logic              d_done_q;
    logic [DWIDTH-1:0] f_rdata_q;
    logic [DWIDTH-1:0] d_rdata_q;
    logic              busy_q;

    assign upd_s = (state_q == ST_IDLE) && (f_req || d_req);

    mem_arb_rr u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .f_req_i (f_req),
        .d_req_i (d_req),
        .upd_i   (upd_s),
        .win_o   (win_s)
    );

    // Access sequencer: grant in IDLE, one memory cycle, one response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_FETCH;
            wdata_q    <= {DWIDTH{1'b0}};
            drive_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {AWIDTH{1'b0}};
            f_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            f_rdata_q  <= {DWIDTH{1'b0}};
            d_rdata_q  <= {DWIDTH{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (upd_s) begin
                        gnt_q  <= win_s;
                        busy_q <= 1'b1;
                        if (win_s == GNT_DATA) begin
                            mem_addr_q <= d_addr;
                            wdata_q    <= d_wdata;
                            if (d_we) begin
                                state_q  <= ST_WRITE;
                                mem_wr_q <= 1'b1;
                                drive_q  <= 1'b1;
                            end else begin
                                state_q  <= ST_READ;
                                mem_rd_q <= 1'b1;
                            end
                        end else begin
                            mem_addr_q <= f_addr;
                            state_q    <= ST_READ;
                            mem_rd_q   <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    mem_rd_q <= 1'b0;
                    state_q  <= ST_RESP;
                    if (gnt_q == GNT_FETCH) begin
                        f_rdata_q <= mem_data;
                        f_done_q  <= 1'b1;
                    end else begin
                        d_rdata_q <= mem_data;
                        d_done_q  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    mem_wr_q <= 1'b0;
                    drive_q  <= 1'b0;
                    d_done_q <= 1'b1;
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    f_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    drive_q  <= 1'b0;
                    f_done_q <= 1'b0;
                    d_done_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    // The bus is driven only during WRITE; drive_q clears asynchronously on reset.
    assign mem_data = drive_q ? wdata_q : {DWIDTH{1'bz}};

    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign f_done   = f_done_q;
    assign d_done   = d_done_q;
    assign f_rdata  = f_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner-case sequences,
// and random traffic scored against a transaction-level model.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       f_req = 1'b0;
    logic [4:0] f_addr = 5'd0;
    logic       f_done;
    logic [7:0] f_rdata;
    logic       d_req = 1'b0;
    logic       d_we = 1'b0;
    logic [4:0] d_addr = 5'd0;
    logic [7:0] d_wdata = 8'd0;
    logic       d_done;
    logic [7:0] d_rdata;
    logic       mem_rd;
    logic       mem_wr;
    logic [4:0] mem_addr;
    wire  [7:0] mem_data;
    logic       busy;

    logic [7:0] mem [32];
    logic       pl_en = 1'b0;
    logic [4:0] pl_a = 5'd0;
    logic [7:0] pl_v = 8'd0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: drives the bus while read-enabled, writes at the clock edge.
    assign mem_data = mem_rd ? mem[mem_addr] : 8'bzzzzzzzz;
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_v;
        else if (mem_wr) mem[mem_addr] <= mem_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_v = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       port;   // 0 fetch, 1 data
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[7];

    // One isolated transaction with cycle-exact checks of access, done and idle return.
    task automatic run_txn(input vec_t v);
        @(negedge clk);
        if (v.port) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            f_req = 1'b1; f_addr = v.addr;
        end
        @(negedge clk);
        chk("txn_mem_rd", mem_rd, !v.we);
        chk("txn_mem_wr", mem_wr, v.we);
        chk("txn_mem_addr", mem_addr, v.addr);
        chk("txn_busy", busy, 1'b1);
        if (v.we) chk("txn_bus_wdata", mem_data, v.wdata);
        @(negedge clk);
        chk("txn_f_done", f_done, !v.port);
        chk("txn_d_done", d_done, v.port);
        chk("txn_rd_wr_off", {mem_rd, mem_wr}, 2'b00);
        if (!v.we) chk("txn_rdata", v.port ? d_rdata : f_rdata, v.exp);
        f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("txn_done_clear", {f_done, d_done}, 2'b00);
        chk("txn_idle", busy, 1'b0);
    endtask

    // Random-phase model state
    logic [7:0] model_mem [32];
    logic       e_valid, e_port, e_we;
    int         e_k, free_at;
    logic [7:0] e_data, m_fr, m_dr;
    logic       m_last, f_pend, d_pend, win;

    initial begin
        vt[0] = '{1'b0, 1'b0, 5'd5,  8'h00, 8'hA5};
        vt[1] = '{1'b1, 1'b1, 5'd3,  8'h3C, 8'h00};
        vt[2] = '{1'b1, 1'b0, 5'd3,  8'h00, 8'h3C};
        vt[3] = '{1'b0, 1'b0, 5'd3,  8'h00, 8'h3C};
        vt[4] = '{1'b1, 1'b1, 5'd31, 8'h5A, 8'h00};
        vt[5] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'h5A};
        vt[6] = '{1'b1, 1'b0, 5'd0,  8'h00, 8'h77};

        // Reset values
        #2;
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_done", {f_done, d_done}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_addr", mem_addr, 5'd0);
        chk("rst_rdata", {f_rdata, d_rdata}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        preload(5'd5, 8'hA5);
        preload(5'd0, 8'h77);

        for (int i = 0; i < 7; i++) run_txn(vt[i]);

        // Both held for four grants: fetch wins the first tie, then strict alternation
        begin
            logic [3:0] order;
            int ng, overlap;
            order = 4'd0; ng = 0; overlap = 0;
            reset_dut();
            @(negedge clk);
            f_req = 1'b1; f_addr = 5'd5;
            d_req = 1'b1; d_we = 1'b0; d_addr = 5'd3;
            for (int c = 0; c < 40 && ng < 4; c++) begin
                @(negedge clk);
                if (mem_rd && mem_wr) overlap++;
                if (f_done || d_done) begin
                    order[ng] = d_done;
                    ng++;
                end
            end
            f_req = 1'b0; d_req = 1'b0;
            chk("rr_grants", ng, 4);
            chk("rr_order", order, 4'b1010);
            chk("rr_no_overlap", overlap, 0);
            @(negedge clk);
        end

        // Data request arriving during a fetch READ waits for the next IDLE
        begin
            int fd, dd;
            fd = -1; dd = -1;
            @(negedge clk);
            f_req = 1'b1; f_addr = 5'd5;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    d_req = 1'b1; d_we = 1'b0; d_addr = 5'd3;
                end
                if (f_done) begin fd = c; f_req = 1'b0; end
                if (d_done) begin dd = c; d_req = 1'b0; end
            end
            chk("late_f_done_cyc", fd, 2);
            chk("late_d_done_cyc", dd, 5);
            chk("late_f_rdata_kept", f_rdata, 8'hA5);
            chk("late_d_rdata", d_rdata, 8'h3C);
        end

        // Reset in the middle of a write: pins drop at once, memory unchanged, no done
        begin
            int ndone;
            ndone = 0;
            preload(5'd7, 8'h11);
            d_req = 1'b1; d_we = 1'b1; d_addr = 5'd7; d_wdata = 8'h99;
            @(negedge clk);
            chk("mid_wr_active", mem_wr, 1'b1);
            chk("mid_wr_bus", mem_data, 8'h99);
            rst_n = 1'b0;
            #1;
            chk("mid_wr_drop", mem_wr, 1'b0);
            chk("mid_rd_drop", mem_rd, 1'b0);
            chk("mid_busy_drop", busy, 1'b0);
            d_req = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 2) rst_n = 1'b1;
                if (f_done || d_done) ndone++;
            end
            chk("mid_no_done", ndone, 0);
            chk("mid_mem7_kept", mem[7], 8'h11);
        end

        // Random traffic against the transaction model
        reset_dut();
        for (int a = 0; a < 32; a++) begin
            logic [7:0] v;
            v = 8'($urandom);
            model_mem[a] = v;
            preload(5'(a), v);
        end
        e_valid = 1'b0; e_port = 1'b0; e_we = 1'b0; e_k = 0; e_data = 8'd0;
        m_fr = 8'd0; m_dr = 8'd0; m_last = 1'b1; f_pend = 1'b0; d_pend = 1'b0;
        free_at = 0;
        for (int it = 0; it < 800; it++) begin
            @(negedge clk);
            if (e_valid && cyc == e_k + 1 && !e_we) begin
                if (e_port) m_dr = e_data; else m_fr = e_data;
            end
            chk("rnd_f_done", f_done, e_valid && !e_port && cyc == e_k + 1);
            chk("rnd_d_done", d_done, e_valid && e_port && cyc == e_k + 1);
            chk("rnd_mem_rd", mem_rd, e_valid && !e_we && cyc == e_k);
            chk("rnd_mem_wr", mem_wr, e_valid && e_we && cyc == e_k);
            chk("rnd_busy", busy, e_valid && (cyc == e_k || cyc == e_k + 1));
            chk("rnd_f_rdata", f_rdata, m_fr);
            chk("rnd_d_rdata", d_rdata, m_dr);
            if (f_done) begin
                f_req = 1'b0; f_pend = 1'b0;
            end else if (!f_pend && $urandom_range(0, 2) == 0) begin
                f_req = 1'b1; f_pend = 1'b1; f_addr = 5'($urandom);
            end
            if (d_done) begin
                d_req = 1'b0; d_pend = 1'b0;
            end else if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_pend = 1'b1; d_we = 1'($urandom);
                d_addr = 5'($urandom); d_wdata = 8'($urandom);
            end
            // The controller can accept a new access every third edge
            if (cyc + 1 >= free_at && (f_req || d_req)) begin
                if (f_req && d_req) win = !m_last;
                else win = d_req;
                e_valid = 1'b1; e_port = win; e_k = cyc + 1;
                e_we = win ? d_we : 1'b0;
                if (e_we) model_mem[d_addr] = d_wdata;
                else e_data = win ? model_mem[d_addr] : model_mem[f_addr];
                m_last = win;
                free_at = cyc + 4;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
